// File: rtl/regs_wb_ctrl.sv
// regs_wb_ctrl: register-file writeback buffer and operand forwarding controller.
// Writebacks are queued in a small circular FIFO and drained into the register
// file whenever wr_hold is low. Decode reads are forwarded from the incoming
// writeback or the youngest matching buffered entry before falling back to the
// register file.
module regs_wb_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        wr_hold,
    output logic [4:0]  rd,
    output logic [31:0] rd_wr_data,
    output logic        rd_wr_en,
    input  logic        rd_req,
    input  logic [4:0]  rs1_req,
    input  logic [4:0]  rs2_req,
    output logic        rs_rd_en,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    input  logic [31:0] rs1_rd_data,
    input  logic [31:0] rs2_rd_data,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic        rs_data_valid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    idx_q  [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic          xfer;
    logic          push;
    logic          pop;

    logic [4:0]    srcIdx;
    logic [PW-1:0] pos;
    logic [31:0]   fwdData_d [2];
    logic          fwdRf_d   [2];

    logic          valid_q;
    logic [31:0]   fwd1_q, fwd2_q;
    logic          useRf1_q, useRf2_q;
    logic [31:0]   hold1_q, hold2_q;

    // Handshake, drain and read-request pass-through; reset forces the
    // buffer to look empty so nothing leaks out while it is being flushed.
    always_comb begin
        wb_ready   = rst || (count_q < FULL);
        xfer       = wb_valid && wb_ready && !rst;
        push       = xfer && (wb_rd != 5'd0);
        rd_wr_en   = !rst && (count_q != '0) && !wr_hold;
        pop        = rd_wr_en;
        rd         = (count_q != '0) ? idx_q[head_q]  : 5'd0;
        rd_wr_data = (count_q != '0) ? data_q[head_q] : 32'd0;
        rs_rd_en   = rd_req;
        rs1        = rs1_req;
        rs2        = rs2_req;
    end

    // Next pointer and occupancy; pointers step with explicit wrap at DEPTH-1.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d = (tail_q == LAST) ? '0 : tail_q + PW'(1);
        end
        if (pop) begin
            head_d = (head_q == LAST) ? '0 : head_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Forwarding decision per source: incoming writeback first, then the
    // youngest live buffer entry (scanned oldest-to-youngest so the last hit
    // wins), otherwise defer to the register file's data next cycle.
    // DEPTH is a power of two, so head+k wraps naturally in PW bits.
    always_comb begin
        srcIdx = 5'd0;
        pos    = '0;
        for (int s = 0; s < 2; s++) begin
            srcIdx       = (s == 0) ? rs1_req : rs2_req;
            fwdData_d[s] = 32'd0;
            fwdRf_d[s]   = 1'b0;
            if (srcIdx == 5'd0) begin
                fwdData_d[s] = 32'd0;
            end else if (push && (wb_rd == srcIdx)) begin
                fwdData_d[s] = wb_data;
            end else begin
                fwdRf_d[s] = 1'b1;
                for (int k = 0; k < DEPTH; k++) begin
                    pos = head_q + PW'(k);
                    if ((CW'(k) < count_q) && (idx_q[pos] == srcIdx)) begin
                        fwdRf_d[s]   = 1'b0;
                        fwdData_d[s] = data_q[pos];
                    end
                end
            end
        end
    end

    // Operand outputs: selected source while valid, last shown value otherwise.
    always_comb begin
        rs_data_valid = valid_q;
        if (valid_q) begin
            rs1_data = useRf1_q ? rs1_rd_data : fwd1_q;
            rs2_data = useRf2_q ? rs2_rd_data : fwd2_q;
        end else begin
            rs1_data = hold1_q;
            rs2_data = hold2_q;
        end
    end

    // Buffer storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            idx_q[tail_q]  <= wb_rd;
            data_q[tail_q] <= wb_data;
        end
    end

    // Pointer/count state and the registered forwarding decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            fwd1_q   <= 32'd0;
            fwd2_q   <= 32'd0;
            useRf1_q <= 1'b0;
            useRf2_q <= 1'b0;
            hold1_q  <= 32'd0;
            hold2_q  <= 32'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= rd_req;
            if (rd_req) begin
                fwd1_q   <= fwdData_d[0];
                fwd2_q   <= fwdData_d[1];
                useRf1_q <= fwdRf_d[0];
                useRf2_q <= fwdRf_d[1];
            end
            if (valid_q) begin
                hold1_q <= rs1_data;
                hold2_q <= rs2_data;
            end
        end
    end

endmodule

// File: doc/regs_wb_ctrl.md
REGS_WB_CTRL -- requirements
Module: regs_wb_ctrl

Interface
REQ-001 Parameter DEPTH, default 2, write-buffer entry count (legal: 2 or 4).
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 wb_valid  input  1  writeback result offered by the MEM/WB stage.
REQ-005 wb_ready  output  1  controller accepts the offered result.
REQ-006 wb_rd  input  5  destination register index.
REQ-007 wb_data  input  32  destination register data.
REQ-008 wr_hold  input  1  blocks buffer drain into the register file this cycle.
REQ-009 rd  output  5  register-file write index.
REQ-010 rd_wr_data  output  32  register-file write data.
REQ-011 rd_wr_en  output  1  register-file write enable.
REQ-012 rd_req  input  1  decode read request.
REQ-013 rs1_req  input  5  decode source-1 index.
REQ-014 rs2_req  input  5  decode source-2 index.
REQ-015 rs_rd_en  output  1  register-file read enable.
REQ-016 rs1  output  5  register-file source-1 index.
REQ-017 rs2  output  5  register-file source-2 index.
REQ-018 rs1_rd_data  input  32  register-file source-1 data, valid one cycle after rs_rd_en.
REQ-019 rs2_rd_data  input  32  register-file source-2 data, valid one cycle after rs_rd_en.
REQ-020 rs1_data  output  32  forwarded source-1 operand.
REQ-021 rs2_data  output  32  forwarded source-2 operand.
REQ-022 rs_data_valid  output  1  rs1_data/rs2_data are valid.

Function
REQ-023 Write buffer: circular FIFO of DEPTH entries {index, data}, with head pointer, tail pointer and count.
REQ-024 Handshake: wb_ready = (count < DEPTH); a transfer occurs when wb_valid && wb_ready at the rising edge.
REQ-025 A transfer with wb_rd == 0 is consumed (handshake completes) but not enqueued.
REQ-026 Drain: rd_wr_en = (count != 0) && !wr_hold; rd/rd_wr_data = head entry, driven combinationally from the buffer.
REQ-027 Pop at the edge where rd_wr_en = 1; push and pop in the same cycle leave count unchanged.
REQ-028 A push into a full buffer never happens; a push when count == DEPTH-1 with a simultaneous pop is legal, since wb_ready depends only on count.
REQ-029 Pointers wrap modulo DEPTH.
REQ-030 Read path: rs_rd_en/rs1/rs2 = rd_req/rs1_req/rs2_req, passed combinationally.
REQ-031 Latency: a request in cycle N sets rs_data_valid = 1 in cycle N+1; rs_data_valid is 0 in cycle N+1 if rd_req = 0 in cycle N.
REQ-032 Forwarding is decided in cycle N and registered at the edge ending cycle N; each source is evaluated independently.
REQ-033 Forwarding priority 1: if the cycle-N transfer targets a nonzero index equal to the source index, use wb_data.
REQ-034 Forwarding priority 2: otherwise, use the youngest valid buffer entry whose index matches, including the head entry being written that cycle.
REQ-035 Forwarding priority 3: otherwise, use rsX_rd_data in cycle N+1.
REQ-036 Source index 0 always yields 32'h0, regardless of buffer contents.
REQ-037 rs1_data/rs2_data hold their last value while rs_data_valid = 0.

Reset
REQ-038 When rst = 1 at an edge: count, head and tail clear to 0, and rs_data_valid clears to 0.
REQ-039 During and after reset: rd_wr_en = 0, wb_ready = 1, rs1_data = rs2_data = 0, rd = 0 and rd_wr_data = 0 while the buffer is empty.
REQ-040 Reset mid-operation discards all buffered writes; no rd_wr_en pulse occurs for them.
REQ-041 rst has priority over any simultaneous handshake or read request.

Verification
REQ-042 Reset 5 cycles, then push x1=0x9876 with wr_hold=0 -> next cycle rd_wr_en=1, rd=1, rd_wr_data=0x9876; the following cycle rd_wr_en=0.
REQ-043 Push x0=0x1234 -> wb_ready=1, no rd_wr_en pulse; a later read of rs1=0 returns 0.
REQ-044 wr_hold=1, push x3=0xA, x3=0xB, then read rs1=3, rs2=3 -> one cycle later rs_data_valid=1 and both operands = 0xB; a push while count=DEPTH -> wb_ready=0, nothing accepted.
REQ-045 In the same cycle push x5=0x55 and read rs1=5, rs2=6 (x6=0x66 already in the register file) -> next cycle rs1_data=0x55, rs2_data=0x66.
REQ-046 Fill the buffer under wr_hold, assert rst for one cycle, release wr_hold -> no rd_wr_en pulses; count=0; wb_ready=1.
REQ-047 Release wr_hold with DEPTH entries buffered -> DEPTH consecutive writes in FIFO order; pointers wrap correctly over 3*DEPTH pushes.
